sample_feeder: RTL and testbench
================================

SAMPLE_FEEDER -- requirements
Module: sample_feeder

Interface
REQ-001 Parameter DEPTH, default 16, SHALL be the maximum number of stored training samples (power of two, at least 2).
REQ-002 Parameter XW, default 7, SHALL be the width of each feature sample (x1, x2).
REQ-003 Parameter TW, default 2, SHALL be the width of the target label (2'b01 = +1, 2'b11 = -1).
REQ-004 clk  in  1  SHALL be the single clock; all logic samples on its rising edge.
REQ-005 rst  in  1  SHALL be a synchronous, active-high reset.
REQ-006 clr  in  1  SHALL be a synchronous dataset clear: count goes to 0 and the state goes to LOAD.
REQ-007 wr_en, wr_x1[XW], wr_x2[XW], wr_t[TW]  in  SHALL be the sample write port.
REQ-008 start  in  1  SHALL be a level request to begin or rewind serving.
REQ-009 ReadEn  in  1  SHALL be the learner's next-sample request; only its rising edge counts.
REQ-010 Ready  in  1  SHALL be the learner's training-complete indication.
REQ-011 x1Data[XW], x2Data[XW], tData[TW]  out  SHALL be the presented sample, registered.
REQ-012 data_valid  out  1  SHALL be high while the presented sample is valid in SERVE.
REQ-013 epoch_done  out  1  SHALL be a one-cycle pulse on each dataset wrap.
REQ-014 epoch_count[16]  out  SHALL count completed epochs, saturating at 16'hFFFF.
REQ-015 count[log2(DEPTH)+1], full, empty, overflow  out  SHALL be status; overflow is sticky.

Function
REQ-016 The block SHALL implement the states LOAD, SERVE and DONE.
REQ-017 In LOAD, wr_en with count<DEPTH SHALL write mem[count] and increment count in the same cycle.
REQ-018 In LOAD, wr_en with full high SHALL be dropped, set overflow and leave count unchanged.
REQ-019 wr_en SHALL be ignored in SERVE and DONE.
REQ-020 start high in LOAD with count>0 SHALL move to SERVE, set rd_ptr=0 and present sample 0 with data_valid=1 one cycle later.
REQ-021 start high with count==0 SHALL leave the state in LOAD.
REQ-022 A ReadEn rising edge (ReadEn=1, previous ReadEn=0) in SERVE SHALL advance rd_ptr.
REQ-023 After a ReadEn advance, the new sample SHALL appear on the outputs on the next cycle, with data_valid held high throughout.
REQ-024 An advance from rd_ptr==count-1 SHALL wrap rd_ptr to 0, pulse epoch_done and increment epoch_count.
REQ-025 Ready high in SERVE SHALL move to DONE and drop data_valid; it SHALL take priority over a simultaneous ReadEn edge, which is then ignored.
REQ-026 In DONE, the sample outputs SHALL hold their last value.
REQ-027 start in DONE SHALL rewind to SERVE at sample 0 without clearing epoch_count.
REQ-028 clr SHALL have priority over start and ReadEn.
REQ-029 clr SHALL zero count, rd_ptr and overflow, clear data_valid and return to LOAD; epoch_count SHALL be kept.

Reset
REQ-030 rst SHALL force LOAD, count=0, rd_ptr=0, all outputs 0, overflow=0 and epoch_count=0.
REQ-031 rst SHALL override all other inputs, including mid-SERVE; memory contents SHALL be left undefined after reset.

Configuration
REQ-032 With FEEDER_EPOCH_LIMIT_EN defined, parameter MAX_EPOCHS (default 100) SHALL exist, and reaching epoch_count==MAX_EPOCHS SHALL force DONE and assert the output limit_hit (sticky until rst or clr).
REQ-033 Without FEEDER_EPOCH_LIMIT_EN, neither limit_hit nor MAX_EPOCHS SHALL exist, and serving SHALL continue until Ready.

Structure
REQ-034 Package learn_pkg SHALL hold XW, TW, the label constants T_POS and T_NEG, and the state enum.
REQ-035 Storage SHALL be the sub-module sample_mem: 1 write port, 1 read port, synchronous read, DEPTH x (2*XW+TW).

Verification
REQ-036 Write 4 samples (x1 = 2, 13, 111, 122), pulse start -> count=4; next cycle x1Data=7'd2, data_valid=1.
REQ-037 Apply 4 ReadEn rising edges -> x1Data steps through 13, 111, 122, then 2; epoch_done pulses once; epoch_count=1.
REQ-038 Hold ReadEn high for 5 cycles -> exactly one advance.
REQ-039 Write 17 samples with DEPTH=16 -> count=16, full=1, overflow=1.
REQ-040 Raise Ready on the same cycle as a ReadEn edge -> DONE, data_valid=0, outputs unchanged; then start -> sample 0 presented again.
REQ-041 Assert rst mid-SERVE -> next cycle state=LOAD, all outputs 0, epoch_count=0.
REQ-042 With FEEDER_EPOCH_LIMIT_EN and MAX_EPOCHS=2 -> after 2 wraps, limit_hit=1 and data_valid=0.

Source files
------------

// File: rtl/learn_pkg.sv
// Shared constants and state encoding for the training-sample feeder.
package learn_pkg;

  localparam int XW = 7;
  localparam int TW = 2;

  localparam logic [TW-1:0] T_POS = 2'b01;
  localparam logic [TW-1:0] T_NEG = 2'b11;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    SERVE = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/sample_mem.sv
// Simple dual-port sample store: one write port, one synchronous read port.
module sample_mem #(
  parameter int DEPTH = 16,
  parameter int W     = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wrEn,
  input  logic [AW-1:0] wrAddr,
  input  logic [W-1:0]  wrData,
  input  logic          rdEn,
  input  logic [AW-1:0] rdAddr,
  output logic [W-1:0]  rdData
);

  logic [W-1:0] mem [DEPTH];

  // NOTE: the storage array has no reset; only the read register is cleared.
  always_ff @(posedge clk) begin
    if (wrEn) mem[wrAddr] <= wrData;
  end

  // NOTE: non-blocking assignments keep every register sampling pre-edge values.
  always_ff @(posedge clk) begin
    if (rst)       rdData <= '0;
    else if (rdEn) rdData <= mem[rdAddr];
  end

endmodule

// File: rtl/sample_feeder.sv
// Loads a training set, then serves it sample by sample to a learner.
// Optional epoch limit enabled by defining FEEDER_EPOCH_LIMIT_EN.
module sample_feeder #(
  parameter int DEPTH = 16,
  parameter int XW    = learn_pkg::XW,
  parameter int TW    = learn_pkg::TW
`ifdef FEEDER_EPOCH_LIMIT_EN
  , parameter int MAX_EPOCHS = 100
`endif
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     wr_en,
  input  logic [XW-1:0]            wr_x1,
  input  logic [XW-1:0]            wr_x2,
  input  logic [TW-1:0]            wr_t,
  input  logic                     start,
  input  logic                     ReadEn,
  input  logic                     Ready,
  output logic [XW-1:0]            x1Data,
  output logic [XW-1:0]            x2Data,
  output logic [TW-1:0]            tData,
  output logic                     data_valid,
  output logic                     epoch_done,
  output logic [15:0]              epoch_count,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  output logic                     overflow
`ifdef FEEDER_EPOCH_LIMIT_EN
  , output logic                   limit_hit
`endif
);

  import learn_pkg::state_t;
  import learn_pkg::LOAD;
  import learn_pkg::SERVE;
  import learn_pkg::DONE;

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = 2 * XW + TW;

  state_t        state, stateNext;
  logic [AW-1:0] rdPtr, rdAddr;
  logic          readEnQ, readEdge, lastIdx;
  logic          doWrite, dropWrite, rdEn, advance, wrap, rewind, hitLimit;
  logic [15:0]   epochInc;
  logic [SW-1:0] rdData;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign readEdge = ReadEn & ~readEnQ;
  assign lastIdx  = ({1'b0, rdPtr} == count - CW'(1));
  assign epochInc = (epoch_count == 16'hFFFF) ? epoch_count : epoch_count + 16'd1;

  always_ff @(posedge clk) begin
    if (rst) state <= LOAD;
    else     state <= stateNext;
  end

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    stateNext = state;
    doWrite   = 1'b0;
    dropWrite = 1'b0;
    rdEn      = 1'b0;
    rdAddr    = rdPtr;
    advance   = 1'b0;
    wrap      = 1'b0;
    rewind    = 1'b0;
    hitLimit  = 1'b0;
    if (clr) begin
      stateNext = LOAD;
    end else begin
      case (state)
        LOAD: begin
          if (wr_en) begin
            if (full) dropWrite = 1'b1;
            else      doWrite   = 1'b1;
          end
          if (start && !empty) begin
            stateNext = SERVE;
            rewind    = 1'b1;
            rdEn      = 1'b1;
            rdAddr    = '0;
          end
        end
        SERVE: begin
          // Ready wins over a coincident ReadEn edge
          if (Ready) begin
            stateNext = DONE;
          end else if (readEdge) begin
            advance = 1'b1;
            rdEn    = 1'b1;
            if (lastIdx) begin
              wrap   = 1'b1;
              rdAddr = '0;
`ifdef FEEDER_EPOCH_LIMIT_EN
              if (epochInc == 16'(MAX_EPOCHS)) begin
                stateNext = DONE;
                hitLimit  = 1'b1;
                rdEn      = 1'b0;
              end
`endif
            end else begin
              rdAddr = rdPtr + AW'(1);
            end
          end
        end
        DONE: begin
`ifdef FEEDER_EPOCH_LIMIT_EN
          if (start && !limit_hit) begin
`else
          if (start) begin
`endif
            stateNext = SERVE;
            rewind    = 1'b1;
            rdEn      = 1'b1;
            rdAddr    = '0;
          end
        end
        default: stateNext = LOAD;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count       <= '0;
      rdPtr       <= '0;
      overflow    <= 1'b0;
      data_valid  <= 1'b0;
      epoch_done  <= 1'b0;
      epoch_count <= '0;
      readEnQ     <= 1'b0;
    end else begin
      readEnQ    <= ReadEn;
      epoch_done <= wrap;
      data_valid <= (stateNext == SERVE);
      if (clr) begin
        count    <= '0;
        rdPtr    <= '0;
        overflow <= 1'b0;
      end else begin
        if (doWrite)   count    <= count + CW'(1);
        if (dropWrite) overflow <= 1'b1;
        if (rewind)       rdPtr <= '0;
        else if (advance) rdPtr <= wrap ? '0 : rdPtr + AW'(1);
        if (wrap) epoch_count <= epochInc;
      end
    end
  end

`ifdef FEEDER_EPOCH_LIMIT_EN
  always_ff @(posedge clk) begin
    if (rst || clr)    limit_hit <= 1'b0;
    else if (hitLimit) limit_hit <= 1'b1;
  end
`endif

  sample_mem #(.DEPTH(DEPTH), .W(SW), .AW(AW)) uMem (
    .clk    (clk),
    .rst    (rst),
    .wrEn   (doWrite),
    .wrAddr (count[AW-1:0]),
    .wrData ({wr_x1, wr_x2, wr_t}),
    .rdEn   (rdEn),
    .rdAddr (rdAddr),
    .rdData (rdData)
  );

  assign {x1Data, x2Data, tData} = rdData;

endmodule

// File: tb/tb_sample_feeder.sv
// Scoreboard bench for sample_feeder: stimulus queues expected samples, a monitor checks them.
module tb_sample_feeder;
  import learn_pkg::*;

  typedef struct packed {
    logic [6:0] x1;
    logic [6:0] x2;
    logic [1:0] t;
  } sample_t;

  logic        clk = 1'b0;
  logic        rst, clr, wr_en, start, ReadEn, Ready;
  logic [6:0]  wr_x1, wr_x2, x1Data, x2Data;
  logic [1:0]  wr_t, tData;
  logic        data_valid, epoch_done, full, empty, overflow;
  logic [15:0] epoch_count;
  logic [4:0]  count;
`ifdef FEEDER_EPOCH_LIMIT_EN
  logic        limit_hit;
`endif

  int nCompared   = 0;
  int nMismatched = 0;
  sample_t expQ[$];
  sample_t s4[4];

  always #5 clk = ~clk;

  sample_feeder #(
    .DEPTH(16)
`ifdef FEEDER_EPOCH_LIMIT_EN
    , .MAX_EPOCHS(2)
`endif
  ) dut (
    .clk(clk), .rst(rst), .clr(clr), .wr_en(wr_en),
    .wr_x1(wr_x1), .wr_x2(wr_x2), .wr_t(wr_t),
    .start(start), .ReadEn(ReadEn), .Ready(Ready),
    .x1Data(x1Data), .x2Data(x2Data), .tData(tData),
    .data_valid(data_valid), .epoch_done(epoch_done), .epoch_count(epoch_count),
    .count(count), .full(full), .empty(empty), .overflow(overflow)
`ifdef FEEDER_EPOCH_LIMIT_EN
    , .limit_hit(limit_hit)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic writeSample(input sample_t s);
    wr_en = 1'b1;
    wr_x1 = s.x1;
    wr_x2 = s.x2;
    wr_t  = s.t;
    tick();
    wr_en = 1'b0;
  endtask

  // Monitor: a new presentation is valid rising or a changed sample while valid.
  logic    prevValid = 1'b0;
  sample_t prevSample = '0;
  always @(negedge clk) begin
    sample_t cur, e;
    cur = {x1Data, x2Data, tData};
    if (rst) begin
      prevValid = 1'b0;
    end else begin
      if (data_valid && (!prevValid || cur != prevSample)) begin
        nCompared++;
        if (expQ.size() == 0) begin
          nMismatched++;
          $display("FAIL sample_unexpected: got x1=%0d x2=%0d t=%0d, expected no new sample",
                   cur.x1, cur.x2, cur.t);
        end else begin
          e = expQ.pop_front();
          if (cur !== e) begin
            nMismatched++;
            $display("FAIL sample: got x1=%0d x2=%0d t=%0d, expected x1=%0d x2=%0d t=%0d",
                     cur.x1, cur.x2, cur.t, e.x1, e.x2, e.t);
          end
        end
      end
      prevValid  = data_valid;
      prevSample = cur;
    end
  end

  initial begin
    s4[0] = '{x1: 7'd2,   x2: 7'd5,  t: T_POS};
    s4[1] = '{x1: 7'd13,  x2: 7'd64, t: T_NEG};
    s4[2] = '{x1: 7'd111, x2: 7'd99, t: T_POS};
    s4[3] = '{x1: 7'd122, x2: 7'd1,  t: T_NEG};

    rst = 1'b1; clr = 1'b0; wr_en = 1'b0; start = 1'b0; ReadEn = 1'b0; Ready = 1'b0;
    wr_x1 = '0; wr_x2 = '0; wr_t = '0;
    tick(); tick();
    rst = 1'b0;
    check("rst_count", 32'(count), 0);
    check("rst_empty", 32'(empty), 1);
    check("rst_full", 32'(full), 0);
    check("rst_overflow", 32'(overflow), 0);
    check("rst_valid", 32'(data_valid), 0);
    check("rst_x1", 32'(x1Data), 0);
    check("rst_epoch", 32'(epoch_count), 0);

    // Load four samples and start serving
    for (int i = 0; i < 4; i++) writeSample(s4[i]);
    check("load_count", 32'(count), 4);
    start = 1'b1;
    expQ.push_back(s4[0]);
    tick();
    start = 1'b0;
    check("start_valid", 32'(data_valid), 1);
    check("start_x1", 32'(x1Data), 2);

    // Four ReadEn edges walk the set and wrap once
    for (int i = 0; i < 4; i++) begin
      ReadEn = 1'b1;
      expQ.push_back(s4[(i + 1) % 4]);
      tick();
      check("epoch_done_pulse", 32'(epoch_done), (i == 3) ? 1 : 0);
      ReadEn = 1'b0;
      tick();
    end
    check("epoch_done_clear", 32'(epoch_done), 0);
    check("epoch_count_1", 32'(epoch_count), 1);

    // ReadEn held high gives a single advance
    ReadEn = 1'b1;
    expQ.push_back(s4[1]);
    repeat (5) tick();
    ReadEn = 1'b0;
    tick();
    check("hold_x1", 32'(x1Data), 13);

    // Ready beats a simultaneous ReadEn edge
    ReadEn = 1'b1;
    Ready  = 1'b1;
    tick();
    check("done_valid", 32'(data_valid), 0);
    check("done_x1", 32'(x1Data), 13);
    check("done_x2", 32'(x2Data), 64);
    Ready  = 1'b0;
    ReadEn = 1'b0;
    tick();
    check("done_hold_valid", 32'(data_valid), 0);
    start = 1'b1;
    expQ.push_back(s4[0]);
    tick();
    start = 1'b0;
    check("rewind_valid", 32'(data_valid), 1);
    check("rewind_epoch", 32'(epoch_count), 1);

    // clr beats start and ReadEn, keeps epoch_count
    clr = 1'b1; start = 1'b1; ReadEn = 1'b1;
    tick();
    clr = 1'b0; start = 1'b0; ReadEn = 1'b0;
    check("clr_count", 32'(count), 0);
    check("clr_valid", 32'(data_valid), 0);
    check("clr_empty", 32'(empty), 1);
    check("clr_epoch", 32'(epoch_count), 1);

    // Seventeen writes into a 16-deep store
    for (int i = 0; i < 17; i++)
      writeSample('{x1: 7'(30 + i), x2: 7'(i), t: (i % 2 == 1) ? T_NEG : T_POS});
    check("ovf_count", 32'(count), 16);
    check("ovf_full", 32'(full), 1);
    check("ovf_flag", 32'(overflow), 1);
    start = 1'b1;
    expQ.push_back('{x1: 7'd30, x2: 7'd0, t: T_POS});
    tick();
    start = 1'b0;
    ReadEn = 1'b1;
    expQ.push_back('{x1: 7'd31, x2: 7'd1, t: T_NEG});
    tick();
    ReadEn = 1'b0;
    tick();
    check("ovf_sticky", 32'(overflow), 1);

    // Reset in the middle of serving
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_valid", 32'(data_valid), 0);
    check("mid_rst_x1", 32'(x1Data), 0);
    check("mid_rst_x2", 32'(x2Data), 0);
    check("mid_rst_t", 32'(tData), 0);
    check("mid_rst_count", 32'(count), 0);
    check("mid_rst_ovf", 32'(overflow), 0);
    check("mid_rst_epoch", 32'(epoch_count), 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("empty_start_valid", 32'(data_valid), 0);

`ifdef FEEDER_EPOCH_LIMIT_EN
    // Two-sample set, limit of two epochs
    writeSample(s4[0]);
    writeSample(s4[1]);
    start = 1'b1;
    expQ.push_back(s4[0]);
    tick();
    start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      ReadEn = 1'b1;
      if (k < 3) expQ.push_back(s4[(k + 1) % 2]);
      tick();
      ReadEn = 1'b0;
      tick();
    end
    check("limit_hit", 32'(limit_hit), 1);
    check("limit_valid", 32'(data_valid), 0);
    check("limit_epoch", 32'(epoch_count), 2);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("limit_blocks_start", 32'(data_valid), 0);
`endif

    tick(); tick();
    check("scoreboard_drained", 32'(expQ.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
